// File: rtl/btn_mode_sel_if.sv
// Button/mode signal bundle between the board button conditioner and the LED
// pattern generator's mode select.
interface btn_mode_sel_if;
    logic       btn_in;
    logic       btn_level;
    logic [1:0] mode;
    logic       mode_changed;
    logic       long_press;

    // Conditioner side: samples the raw button, drives the mode outputs.
    modport master (
        input  btn_in,
        output btn_level,
        output mode,
        output mode_changed,
        output long_press
    );

    // Consumer side: supplies the raw button, observes the mode outputs.
    modport slave (
        output btn_in,
        input  btn_level,
        input  mode,
        input  mode_changed,
        input  long_press
    );
endinterface

// File: rtl/btn_mode_sel.sv
// Push-button conditioner: synchronizes and debounces a raw button, classifies
// short/long presses and maintains the 2-bit LED mode register.
module btn_mode_sel #(
    parameter int unsigned CLK_FREQ      = 100_000_000,
    parameter int unsigned DEBOUNCE_MS   = 20,
    parameter int unsigned LONG_PRESS_MS = 1000,
    parameter int unsigned NUM_MODES     = 4,
    parameter int unsigned INIT_MODE     = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    btn_mode_sel_if.master bus
);

    localparam int unsigned DB_TICKS = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int unsigned LP_TICKS = CLK_FREQ / 1000 * LONG_PRESS_MS;
    localparam int unsigned DB_W     = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
    localparam int unsigned LP_W     = (LP_TICKS > 1) ? $clog2(LP_TICKS) : 1;
    localparam int unsigned MODE_W   = 2;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_TICKS - 1);
    localparam logic [LP_W-1:0]   LP_LAST   = LP_W'(LP_TICKS - 1);
    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);
    localparam logic [MODE_W-1:0] MODE_RST  = MODE_W'(INIT_MODE);

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_PRESSED = 2'b01;
    localparam logic [1:0] ST_HELD    = 2'b10;

    // Parameter sanity, caught at elaboration.
    if (DB_TICKS < 1) begin : g_bad_db
        $error("btn_mode_sel: DB_TICKS must be >= 1");
    end
    if (LP_TICKS < 2) begin : g_bad_lp
        $error("btn_mode_sel: LP_TICKS must be > 1");
    end
    if (NUM_MODES < 1 || NUM_MODES > 4) begin : g_bad_nm
        $error("btn_mode_sel: NUM_MODES must be 1..4");
    end
    if (INIT_MODE >= NUM_MODES) begin : g_bad_im
        $error("btn_mode_sel: INIT_MODE must be < NUM_MODES");
    end

    logic              s1_q, s1_d;
    logic              s2_q, s2_d;
    logic              stable_q, stable_d;
    logic              stable_dly_q, stable_dly_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [LP_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [1:0]        state_q, state_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              mode_changed_q, mode_changed_d;
    logic              long_press_q, long_press_d;

    // Two-flop synchronizer and debouncer; any agreeing cycle restarts the count.
    always_comb begin
        s1_d         = bus.btn_in;
        s2_d         = s1_q;
        stable_d     = stable_q;
        db_cnt_d     = db_cnt_q;
        stable_dly_d = stable_q;
        if (s2_q == stable_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            stable_d = s2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    // Press classifier; release is checked before the long-press threshold.
    always_comb begin
        state_d        = state_q;
        hold_cnt_d     = hold_cnt_q;
        mode_d         = mode_q;
        mode_changed_d = 1'b0;
        long_press_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (stable_q && !stable_dly_q) begin
                    state_d    = ST_PRESSED;
                    hold_cnt_d = '0;
                end
            end
            ST_PRESSED: begin
                if (!stable_q) begin
                    mode_d         = (mode_q == MODE_LAST) ? '0 : mode_q + MODE_W'(1);
                    mode_changed_d = 1'b1;
                    state_d        = ST_IDLE;
                end else if (hold_cnt_q == LP_LAST) begin
                    long_press_d   = 1'b1;
                    mode_d         = '0;
                    mode_changed_d = (mode_q != '0);
                    state_d        = ST_HELD;
                end else begin
                    hold_cnt_d = hold_cnt_q + LP_W'(1);
                end
            end
            ST_HELD: begin
                if (!stable_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            stable_q       <= 1'b0;
            stable_dly_q   <= 1'b0;
            db_cnt_q       <= '0;
            hold_cnt_q     <= '0;
            state_q        <= ST_IDLE;
            mode_q         <= MODE_RST;
            mode_changed_q <= 1'b0;
            long_press_q   <= 1'b0;
        end else begin
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            stable_q       <= stable_d;
            stable_dly_q   <= stable_dly_d;
            db_cnt_q       <= db_cnt_d;
            hold_cnt_q     <= hold_cnt_d;
            state_q        <= state_d;
            mode_q         <= mode_d;
            mode_changed_q <= mode_changed_d;
            long_press_q   <= long_press_d;
        end
    end

    assign bus.btn_level    = stable_q;
    assign bus.mode         = mode_q;
    assign bus.mode_changed = mode_changed_q;
    assign bus.long_press   = long_press_q;

endmodule

// File: tb/tb_btn_mode_sel.sv
// Scoreboard bench for btn_mode_sel: expected pulse events are queued by the
// stimulus and matched by an independent monitor on every output pulse.
module tb_btn_mode_sel;

    typedef struct packed {
        logic [1:0] mode;
        logic       mc;
        logic       lp;
        logic [7:0] lat;
    } ev_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   cyc;
    int   lvl_cyc;
    logic lvl_prev;
    ev_t  exp_q[$];

    btn_mode_sel_if bus ();

    btn_mode_sel #(
        .CLK_FREQ     (1000),
        .DEBOUNCE_MS  (4),
        .LONG_PRESS_MS(20),
        .NUM_MODES    (4),
        .INIT_MODE    (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    endtask

    // Monitor: every pulse must match the head of the scoreboard, including
    // its latency from the last btn_level change.
    always @(negedge clk) begin
        if (rst_n && (bus.mode_changed || bus.long_press)) begin
            ev_t act;
            ev_t expv;
            act.mode = bus.mode;
            act.mc   = bus.mode_changed;
            act.lp   = bus.long_press;
            act.lat  = 8'(cyc - lvl_cyc);
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_pulse: got mode=%0d mc=%0b lp=%0b lat=%0d expected no pulse",
                         act.mode, act.mc, act.lp, act.lat);
            end else begin
                expv = exp_q.pop_front();
                if (act === expv) n_pass++;
                else $display("FAIL pulse_event: got mode=%0d mc=%0b lp=%0b lat=%0d expected mode=%0d mc=%0b lp=%0b lat=%0d",
                              act.mode, act.mc, act.lp, act.lat, expv.mode, expv.mc, expv.lp, expv.lat);
            end
        end
        if (bus.btn_level !== lvl_prev) begin
            lvl_cyc  = cyc;
            lvl_prev = bus.btn_level;
        end
    end

    task automatic push_ev(input logic [1:0] m, input logic mc, input logic lp, input int lat);
        ev_t e;
        e.mode = m;
        e.mc   = mc;
        e.lp   = lp;
        e.lat  = 8'(lat);
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        int budget = 60;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic press(input int high_cyc);
        @(negedge clk);
        bus.btn_in = 1'b1;
        repeat (high_cyc) @(negedge clk);
        bus.btn_in = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        n_checks   = 0;
        n_pass     = 0;
        cyc        = 0;
        lvl_cyc    = 0;
        lvl_prev   = 1'b0;
        rst_n      = 1'b0;
        bus.btn_in = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_mode", 32'(bus.mode), 32'd2);
        check("rst_level", 32'(bus.btn_level), 32'd0);
        check("rst_mc", 32'(bus.mode_changed), 32'd0);
        check("rst_lp", 32'(bus.long_press), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_hold", {bus.mode, bus.btn_level, bus.mode_changed, bus.long_press}, {2'd2, 3'b000});

        // Bounce: 3 high / 1 low never reaches 4 stable cycles.
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.btn_in = 1'b1;
            repeat (3) begin @(negedge clk); seen |= bus.btn_level; end
            bus.btn_in = 1'b0;
            @(negedge clk); seen |= bus.btn_level;
        end
        check("bounce_level", 32'(seen), 32'd0);

        // Clean hold: level rises on the 6th edge; released after 10 more cycles.
        push_ev(2'd3, 1'b1, 1'b0, 1);
        bus.btn_in = 1'b1;
        repeat (5) @(negedge clk);
        check("db_lat_5", 32'(bus.btn_level), 32'd0);
        @(negedge clk);
        check("db_lat_6", 32'(bus.btn_level), 32'd1);
        repeat (10) @(negedge clk);
        bus.btn_in = 1'b0;
        repeat (12) @(negedge clk);
        drain("short_2_3");

        push_ev(2'd0, 1'b1, 1'b0, 1);  press(10); drain("short_3_0");
        push_ev(2'd1, 1'b1, 1'b0, 1);  press(10); drain("short_0_1");
        push_ev(2'd2, 1'b1, 1'b0, 1);  press(10); drain("short_1_2");
        push_ev(2'd3, 1'b1, 1'b0, 1);  press(10); drain("short_2_3b");
        check("pre_long_mode", 32'(bus.mode), 32'd3);

        // Long press from mode 3: both pulses 21 edges after btn_level rises.
        push_ev(2'd0, 1'b1, 1'b1, 21); press(40); drain("long_3");
        check("post_long_mode", 32'(bus.mode), 32'd0);

        push_ev(2'd0, 1'b0, 1'b1, 21); press(40); drain("long_0");
        check("post_long0_mode", 32'(bus.mode), 32'd0);

        push_ev(2'd1, 1'b1, 1'b0, 1);  press(10); drain("short_0_1b");

        // Reset while in PRESSED at mode 1.
        @(negedge clk);
        bus.btn_in = 1'b1;
        repeat (10) @(negedge clk);
        check("midpress_level", 32'(bus.btn_level), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_mode", 32'(bus.mode), 32'd2);
        check("midrst_level", 32'(bus.btn_level), 32'd0);
        check("midrst_pulses", {bus.mode_changed, bus.long_press}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        bus.btn_in = 1'b0;
        seen = 1'b0;
        repeat (30) begin @(negedge clk); seen |= bus.btn_level; end
        check("postrst_level", 32'(seen), 32'd0);
        check("postrst_mode", 32'(bus.mode), 32'd2);
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
